// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu -- multiply/divide unit with HI/LO result registers.
//
// A mult-class or div-class Start taken in IDLE computes the result at once
// and holds it in a private latch. HI/LO are written only when the cycle
// counter expires, so the outputs never show partial results.
// MTHI/MTLO write HI/LO directly from IDLE and do not set Busy.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   Start    request strobe, sampled together with MDOp
//   MDOp     0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO,
//            7 MADD, 8 MADDU, other codes are ignored
//   NumberA  rs operand
//   NumberB  rt operand
//   Busy     high while a mult/div operation is in flight
//   HI, LO   committed result registers
//
// Optional feature macro: MDU_MADD_EN. When it is defined, MADD and MADDU
// accumulate into {HI,LO}. When it is undefined, MDOp 7 and 8 act as none.
// ---------------------------------------------------------------------------
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [3:0]  MDOp,
   input  logic [31:0] NumberA,
   input  logic [31:0] NumberB,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_MUL  = 2'd1;
   localparam logic [1:0] S_DIV  = 2'd2;

   logic [1:0]  state;
   logic [3:0]  cnt;
   logic [63:0] res;       // pending {HI,LO}
   logic        res_vld;   // cleared for divide-by-zero, so nothing commits

   // ---------------- multiply ----------------
   logic [63:0] prod_s, prod_u, mul_res;
   logic        is_mul, is_div;

   assign prod_s = {{32{NumberA[31]}}, NumberA} * {{32{NumberB[31]}}, NumberB};
   assign prod_u = {32'd0, NumberA} * {32'd0, NumberB};

`ifdef MDU_MADD_EN
   assign is_mul = (MDOp == 4'd1) || (MDOp == 4'd2) || (MDOp == 4'd7) || (MDOp == 4'd8);
`else
   assign is_mul = (MDOp == 4'd1) || (MDOp == 4'd2);
`endif
   assign is_div = (MDOp == 4'd3) || (MDOp == 4'd4);

   // HI/LO cannot change while Busy is high, so the accumulate term can be
   // taken at accept time instead of at commit time.
   always_comb begin
      mul_res = prod_u;
      case (MDOp)
         4'd1:    mul_res = prod_s;
`ifdef MDU_MADD_EN
         4'd7:    mul_res = {HI, LO} + prod_s;
         4'd8:    mul_res = {HI, LO} + prod_u;
`endif
         default: mul_res = prod_u;
      endcase
   end

   // ---------------- divide ----------------
   // The signed divide runs on magnitudes. The quotient is negated when the
   // operand signs differ, and the remainder takes the sign of the dividend.
   // For 0x80000000 / -1, the magnitude of the quotient is 0x80000000 and it
   // is not negated, so LO = 0x80000000 and HI = 0 with no special case.
   logic        sgn_a, sgn_b, div_signed;
   logic [31:0] mag_a, mag_b, q_mag, r_mag, quo, rem;

   assign div_signed = (MDOp == 4'd3);
   assign sgn_a = div_signed & NumberA[31];
   assign sgn_b = div_signed & NumberB[31];
   assign mag_a = sgn_a ? (~NumberA + 32'd1) : NumberA;
   // A zero divisor is replaced by 1 to keep the divider defined. The result
   // is discarded in that case.
   assign mag_b = (NumberB == 32'd0) ? 32'd1 : (sgn_b ? (~NumberB + 32'd1) : NumberB);
   assign q_mag = mag_a / mag_b;
   assign r_mag = mag_a % mag_b;
   assign quo   = (sgn_a ^ sgn_b) ? (~q_mag + 32'd1) : q_mag;
   assign rem   = sgn_a ? (~r_mag + 32'd1) : r_mag;

   // ---------------- control ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         Busy    <= 1'b0;
         HI      <= 32'd0;
         LO      <= 32'd0;
         res     <= 64'd0;
         res_vld <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (Start) begin
                  if (is_mul) begin
                     res     <= mul_res;
                     res_vld <= 1'b1;
                     cnt     <= 4'(MULT_CYCLES);
                     Busy    <= 1'b1;
                     state   <= S_MUL;
                  end else if (is_div) begin
                     res     <= {rem, quo};
                     res_vld <= (NumberB != 32'd0);
                     cnt     <= 4'(DIV_CYCLES);
                     Busy    <= 1'b1;
                     state   <= S_DIV;
                  end else if (MDOp == 4'd5) begin
                     HI <= NumberA;
                  end else if (MDOp == 4'd6) begin
                     LO <= NumberA;
                  end
               end
            end
            S_MUL, S_DIV: begin
               // Start is ignored here. Only the counter makes progress.
               if (cnt == 4'd1) begin
                  if (res_vld) begin
                     HI <= res[63:32];
                     LO <= res[31:0];
                  end
                  cnt   <= 4'd0;
                  Busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            default: begin
               state <= S_IDLE;
               Busy  <= 1'b0;
               cnt   <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: cycles from accepted mult-class Start to HI/LO commit; legal 1..15.
REQ-002 Parameter DIV_CYCLES, default 10: cycles from accepted div-class Start to HI/LO commit; legal 1..15.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; reset==0 resets the block.
REQ-005 Start  input  1  EX-stage request; sampled with MDOp on the rising edge.
REQ-006 MDOp  input  4  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 MADD, 8 MADDU, others none.
REQ-007 NumberA  input  32  rs operand, post-forwarding.
REQ-008 NumberB  input  32  rt operand, post-forwarding.
REQ-009 Busy  output  1  registered; high while a mult/div operation is in flight.
REQ-010 HI  output  32  registered HI value.
REQ-011 LO  output  32  registered LO value.

Function
REQ-012 States SHALL be IDLE, MUL, DIV; a 4-bit down-counter SHALL track remaining cycles.
REQ-013 In IDLE, Start with MDOp 1/2/7/8 SHALL latch the result, load counter with MULT_CYCLES, and go to MUL.
REQ-014 In IDLE, Start with MDOp 3/4 and NumberB!=0 SHALL latch quotient/remainder, load counter with DIV_CYCLES, and go to DIV.
REQ-015 DIV/DIVU with NumberB==0 SHALL enter DIV for DIV_CYCLES, then commit nothing; HI/LO stay unchanged.
REQ-016 In MUL/DIV the counter SHALL decrement each cycle; at count 1 the next edge SHALL commit HI/LO, clear Busy, and return to IDLE.
REQ-017 Timing: Start sampled at edge k gives Busy=1 after edge k through edge k+N-1, and HI/LO plus Busy=0 after edge k+N (N = cycle parameter).
REQ-018 MULT: {HI,LO} = signed 64-bit product; MULTU: unsigned product.
REQ-019 DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend. DIVU: unsigned.
REQ-020 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0x00000000.
REQ-021 MTHI/MTLO in IDLE SHALL write NumberA to HI/LO at that edge, with no Busy.
REQ-022 Any Start while Busy==1 SHALL be ignored; the upstream stall logic prevents this, and the block tolerates it.
REQ-023 Start with MDOp 0 or an undefined code SHALL have no effect.
REQ-024 HI/LO SHALL be readable at any time and SHALL show the committed values only, never partial results.

Reset
REQ-025 reset==0 SHALL immediately force state IDLE, counter 0, Busy=0, HI=0, LO=0, and latched result 0, independent of clk.
REQ-026 Reset during MUL/DIV SHALL abort the operation with no commit; the first Start after reset release SHALL be accepted normally.

Configuration
REQ-027 With MDU_MADD_EN defined, MADD/MADDU SHALL commit {HI,LO} + the signed/unsigned product (mod 2^64) at the MUL commit edge.
REQ-028 Without MDU_MADD_EN, MDOp 7/8 SHALL be treated as none: no Busy and no HI/LO change.

Verification
REQ-029 MULT A=0xFFFFFFFE, B=3, defaults -> Busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 DIV A=0xFFFFFFF9 (-7), B=2 -> after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
REQ-031 MTHI A=0x12345678, then DIVU B=0 -> Busy high for 10 cycles; HI=0x12345678 and LO unchanged.
REQ-032 MULTU A=B=0xFFFFFFFF; reset driven low at cycle 3 of the operation -> Busy=0, HI=LO=0 immediately; no later commit.
REQ-033 MDU_MADD_EN defined: MTLO 5, then MADD A=2, B=3 -> LO=11, HI=0. Without the macro -> LO=5, Busy stays 0.
REQ-034 MULT A=B=2, then Start MULT A=B=3 at busy cycle 2 -> second request ignored; LO=4 at edge k+5.
